// File: rtl/ula_sequencial_pkg.sv
// Shared codes and types for the sequential ALU: opAlu/funct encodings,
// FSM states, internal operation and execution class.
package ula_pkg;

  localparam logic [1:0] OPALU_ADD = 2'b00;
  localparam logic [1:0] OPALU_SUB = 2'b01;
  localparam logic [1:0] OPALU_R   = 2'b10;
  localparam logic [1:0] OPALU_ERR = 2'b11;

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_AND  = 4'b0010;
  localparam logic [3:0] FN_OR   = 4'b0011;
  localparam logic [3:0] FN_SLT  = 4'b0100;
  localparam logic [3:0] FN_XOR  = 4'b0101;
  localparam logic [3:0] FN_NOR  = 4'b0110;
  localparam logic [3:0] FN_SLTU = 4'b0111;
  localparam logic [3:0] FN_SLL  = 4'b1000;
  localparam logic [3:0] FN_SRL  = 4'b1001;
  localparam logic [3:0] FN_SRA  = 4'b1010;
  localparam logic [3:0] FN_MUL  = 4'b1011;

  typedef enum logic {OCIOSO, EXEC} estado_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_XOR, OP_NOR, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_NOP
  } operacao_t;

  typedef enum logic [1:0] {UNICO, ITER, ERRO} classe_t;

endpackage

// File: rtl/ula_sequencial_if.sv
// Request/response bundle between the ALU and its issuing stage.
interface ula_sequencial_if #(
  parameter int LARGURA       = 8,
  parameter int LARGURA_FUNCT = 4
);
  logic                     valid_in;
  logic [1:0]               opAlu;
  logic [LARGURA_FUNCT-1:0] funct;
  logic [LARGURA-1:0]       a;
  logic [LARGURA-1:0]       b;
  logic                     ready_in;
  logic                     valid_out;
  logic [LARGURA-1:0]       resultado;
  logic                     zero;
  logic                     overflow;
  logic                     erro;

  modport master (
    output valid_in, opAlu, funct, a, b,
    input  ready_in, valid_out, resultado, zero, overflow, erro
  );

  modport slave (
    input  valid_in, opAlu, funct, a, b,
    output ready_in, valid_out, resultado, zero, overflow, erro
  );
endinterface

// File: rtl/ula_sequencial_decod.sv
// Combinational control decoder: maps opAlu/funct onto an internal
// operation and its execution class (single-cycle, iterative or error).
module decod_ula
  import ula_pkg::*;
#(
  parameter int LARGURA_FUNCT = 4
) (
  input  logic [1:0]               opAlu,
  input  logic [LARGURA_FUNCT-1:0] funct,
  output operacao_t                op,
  output classe_t                  classe
);

  always_comb begin
    op     = OP_NOP;
    classe = ERRO;
    unique case (opAlu)
      OPALU_ADD: begin op = OP_ADD; classe = UNICO; end
      OPALU_SUB: begin op = OP_SUB; classe = UNICO; end
      OPALU_R: begin
        // Any bit set above the low nibble is an undefined code.
        if ((funct >> 4) == '0) begin
          case (funct[3:0])
            FN_ADD:  begin op = OP_ADD;  classe = UNICO; end
            FN_SUB:  begin op = OP_SUB;  classe = UNICO; end
            FN_AND:  begin op = OP_AND;  classe = UNICO; end
            FN_OR:   begin op = OP_OR;   classe = UNICO; end
            FN_SLT:  begin op = OP_SLT;  classe = UNICO; end
            FN_XOR:  begin op = OP_XOR;  classe = UNICO; end
            FN_NOR:  begin op = OP_NOR;  classe = UNICO; end
            FN_SLTU: begin op = OP_SLTU; classe = UNICO; end
            FN_SLL:  begin op = OP_SLL;  classe = ITER;  end
            FN_SRL:  begin op = OP_SRL;  classe = ITER;  end
            FN_SRA:  begin op = OP_SRA;  classe = ITER;  end
            FN_MUL:  begin op = OP_MUL;  classe = ITER;  end
            default: ;
          endcase
        end
      end
      OPALU_ERR: ;
    endcase
  end

endmodule

// File: rtl/ula_sequencial.sv
// Sequential ALU: single-cycle logic/arithmetic plus iterative shifts and
// shift-add multiply behind a valid/ready handshake.
module ula_sequencial
  import ula_pkg::*;
#(
  parameter int LARGURA       = 8,
  parameter int LARGURA_FUNCT = 4
) (
  input  logic             clk,
  input  logic             reset,
  ula_sequencial_if.slave  bus
);

  localparam int SW = $clog2(LARGURA);
  localparam int CW = SW + 1;

  estado_t            estado, estado_next;
  operacao_t          op_dec, op_reg;
  classe_t            classe_dec;
  logic [CW-1:0]      cnt;
  logic [LARGURA-1:0] acc, mcand, mplier, acc_next;
  logic [LARGURA-1:0] soma, dif, res_unico;
  logic signed [LARGURA-1:0] a_s, b_s, acc_s;
  logic [SW-1:0]      shamt;
  logic               aceita, is_shift, multi, fim, ovf_unico, erro_unico;

  function automatic logic ovf_soma(input logic [LARGURA-1:0] x, y, r);
    return (x[LARGURA-1] == y[LARGURA-1]) && (r[LARGURA-1] != x[LARGURA-1]);
  endfunction

  function automatic logic ovf_sub(input logic [LARGURA-1:0] x, y, r);
    return (x[LARGURA-1] != y[LARGURA-1]) && (r[LARGURA-1] != x[LARGURA-1]);
  endfunction

  decod_ula #(.LARGURA_FUNCT(LARGURA_FUNCT)) u_decod (
    .opAlu  (bus.opAlu),
    .funct  (bus.funct),
    .op     (op_dec),
    .classe (classe_dec)
  );

  assign bus.ready_in = (estado == OCIOSO) && !reset;
  assign aceita   = bus.valid_in && bus.ready_in;
  assign shamt    = bus.b[SW-1:0];
  assign is_shift = (op_dec == OP_SLL) || (op_dec == OP_SRL) || (op_dec == OP_SRA);
  // A shift by zero completes in the single-cycle path.
  assign multi    = aceita && (classe_dec == ITER) && !(is_shift && shamt == '0);
  assign fim      = (estado == EXEC) && (cnt == CW'(1));
  assign a_s      = bus.a;
  assign b_s      = bus.b;
  assign acc_s    = acc;
  assign soma     = bus.a + bus.b;
  assign dif      = bus.a - bus.b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= estado_next;
  end

  always_comb begin
    estado_next = estado;
    case (estado)
      OCIOSO:  if (multi) estado_next = EXEC;
      EXEC:    if (fim)   estado_next = OCIOSO;
      default: estado_next = OCIOSO;
    endcase
  end

  always_comb begin
    res_unico  = '0;
    ovf_unico  = 1'b0;
    erro_unico = (classe_dec == ERRO);
    case (op_dec)
      OP_ADD:  begin res_unico = soma; ovf_unico = ovf_soma(bus.a, bus.b, soma); end
      OP_SUB:  begin res_unico = dif;  ovf_unico = ovf_sub(bus.a, bus.b, dif);   end
      OP_AND:  res_unico = bus.a & bus.b;
      OP_OR:   res_unico = bus.a | bus.b;
      OP_XOR:  res_unico = bus.a ^ bus.b;
      OP_NOR:  res_unico = ~(bus.a | bus.b);
      OP_SLT:  res_unico = {{(LARGURA-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: res_unico = {{(LARGURA-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL, OP_SRL, OP_SRA: res_unico = bus.a;
      default: ;
    endcase
  end

  always_comb begin
    acc_next = acc;
    case (op_reg)
      OP_SLL:  acc_next = acc << 1;
      OP_SRL:  acc_next = acc >> 1;
      OP_SRA:  acc_next = acc_s >>> 1;
      OP_MUL:  acc_next = acc + (mplier[0] ? mcand : '0);
      default: ;
    endcase
  end

  // Acceptance / iteration stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg        <= OP_NOP;
      cnt           <= '0;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      bus.valid_out <= 1'b0;
      bus.resultado <= '0;
      bus.zero      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.erro      <= 1'b0;
    end else begin
      bus.valid_out <= 1'b0;
      if (aceita && !multi) begin
        bus.resultado <= res_unico;
        bus.zero      <= (res_unico == '0);
        bus.overflow  <= ovf_unico;
        bus.erro      <= erro_unico;
        bus.valid_out <= 1'b1;
      end
      if (multi) begin
        op_reg <= op_dec;
        cnt    <= is_shift ? CW'(shamt) : CW'(LARGURA);
        acc    <= is_shift ? bus.a : '0;
        mcand  <= bus.a;
        mplier <= bus.b;
      end
      if (estado == EXEC) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (fim) begin
          bus.resultado <= acc_next;
          bus.zero      <= (acc_next == '0);
          bus.overflow  <= 1'b0;
          bus.erro      <= 1'b0;
          bus.valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed bench for ula_sequencial: vector table plus hand-written
// sequences for busy handshake, back-to-back issue and async reset.
module tb_ula_sequencial;

  logic clk = 1'b0;
  logic reset;
  int   n_run, n_fail;

  ula_sequencial_if #(.LARGURA(8), .LARGURA_FUNCT(4)) bus ();

  ula_sequencial #(.LARGURA(8), .LARGURA_FUNCT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] fn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       o;
    logic       e;
    int         lat;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] fn, input logic [7:0] a, input logic [7:0] b);
    bus.valid_in = 1'b1;
    bus.opAlu    = op;
    bus.funct    = fn;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic run_op(input string nome, input vec_t v);
    int lat;
    @(negedge clk);
    chk({nome, "_rdy"}, 32'(bus.ready_in), 32'd1);
    drive(v.op, v.fn, v.a, v.b);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    lat = 1;
    while (!bus.valid_out && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nome, "_lat"}, 32'(lat), 32'(v.lat));
    chk({nome, "_res"}, 32'(bus.resultado), 32'(v.res));
    chk({nome, "_zero"}, 32'(bus.zero), 32'(v.z));
    chk({nome, "_ovf"}, 32'(bus.overflow), 32'(v.o));
    chk({nome, "_erro"}, 32'(bus.erro), 32'(v.e));
  endtask

  initial begin
    int   spur;
    vec_t seq[4];
    n_run = 0;
    n_fail = 0;
    reset = 1'b0;
    bus.valid_in = 1'b0;
    bus.opAlu = 2'b00;
    bus.funct = 4'h0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    #1 reset = 1'b1;
    #1;
    chk("rst_rdy", 32'(bus.ready_in), 32'd0);
    chk("rst_vout", 32'(bus.valid_out), 32'd0);
    chk("rst_res", 32'(bus.resultado), 32'd0);
    chk("rst_flags", 32'({bus.zero, bus.overflow, bus.erro}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1 chk("rel_rdy", 32'(bus.ready_in), 32'd1);

    //            op     fn     a      b      res    z     o     e    lat
    tab.push_back('{2'b00, 4'h0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1});
    tab.push_back('{2'b00, 4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1});
    tab.push_back('{2'b01, 4'h0, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0, 1});
    tab.push_back('{2'b01, 4'h0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1});
    tab.push_back('{2'b10, 4'h0, 8'h50, 8'h50, 8'hA0, 1'b0, 1'b1, 1'b0, 1});
    tab.push_back('{2'b10, 4'h1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 1});
    tab.push_back('{2'b10, 4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1});
    tab.push_back('{2'b10, 4'h3, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0, 1});
    tab.push_back('{2'b10, 4'h4, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1});
    tab.push_back('{2'b10, 4'h5, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1});
    tab.push_back('{2'b10, 4'h6, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 1});
    tab.push_back('{2'b10, 4'h7, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1});
    tab.push_back('{2'b10, 4'h9, 8'h80, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0, 4});
    tab.push_back('{2'b10, 4'hA, 8'h80, 8'h02, 8'hE0, 1'b0, 1'b0, 1'b0, 3});
    tab.push_back('{2'b10, 4'h8, 8'h01, 8'h08, 8'h01, 1'b0, 1'b0, 1'b0, 1});
    tab.push_back('{2'b10, 4'hB, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b0, 9});
    tab.push_back('{2'b10, 4'hB, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 9});
    tab.push_back('{2'b10, 4'hB, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 9});
    tab.push_back('{2'b11, 4'h0, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1, 1});
    tab.push_back('{2'b10, 4'hF, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1, 1});
    tab.push_back('{2'b10, 4'hC, 8'h55, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1});

    foreach (tab[i]) run_op($sformatf("vec%0d", i), tab[i]);

    // Busy window: sll by 3 with a stray request mid-operation.
    @(negedge clk);
    drive(2'b10, 4'h8, 8'h01, 8'h03);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy%0d_rdy", k), 32'(bus.ready_in), 32'd0);
      chk($sformatf("busy%0d_vout", k), 32'(bus.valid_out), 32'd0);
      if (k == 0) drive(2'b00, 4'h0, 8'h01, 8'h01);
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
    end
    chk("sll3_vout", 32'(bus.valid_out), 32'd1);
    chk("sll3_res", 32'(bus.resultado), 32'h08);
    chk("sll3_rdy", 32'(bus.ready_in), 32'd1);
    spur = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.valid_out) spur++;
    end
    chk("busy_ignored", 32'(spur), 32'd0);

    // Back-to-back single-cycle issue on consecutive edges.
    seq[0] = '{2'b00, 4'h0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1};
    seq[1] = '{2'b01, 4'h0, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    seq[2] = '{2'b10, 4'h4, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1};
    seq[3] = '{2'b10, 4'h7, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(seq[k].op, seq[k].fn, seq[k].a, seq[k].b);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_vout", k), 32'(bus.valid_out), 32'd1);
      chk($sformatf("b2b%0d_res", k), 32'(bus.resultado), 32'(seq[k].res));
      chk($sformatf("b2b%0d_zero", k), 32'(bus.zero), 32'(seq[k].z));
    end
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    chk("b2b_pulse_end", 32'(bus.valid_out), 32'd0);

    // Async reset in the middle of a multiply.
    run_op("pre_rst", '{2'b00, 4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1});
    @(negedge clk);
    drive(2'b10, 4'hB, 8'h0D, 8'h0B);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mrst_vout", 32'(bus.valid_out), 32'd0);
    chk("mrst_res", 32'(bus.resultado), 32'd0);
    chk("mrst_flags", 32'({bus.zero, bus.overflow, bus.erro}), 32'd0);
    chk("mrst_rdy", 32'(bus.ready_in), 32'd0);
    @(negedge clk) reset = 1'b0;
    #1 chk("mrel_rdy", 32'(bus.ready_in), 32'd1);
    spur = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.valid_out) spur++;
    end
    chk("mrel_no_vout", 32'(spur), 32'd0);
    run_op("post_rst", '{2'b00, 4'h0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_sequencial.md
Name: ula_sequencial

Overview:
Parametrised successor to the processor's ALU control path. It merges opAlu/funct decoding with an execution unit of width LARGURA. Single-cycle ops (add, sub, and, or, xor, nor, slt, sltu) return after one clock edge. Shifts and multiply run iteratively over several cycles behind a valid/ready handshake, and the block flags unsupported codes.

Parameters:
LARGURA, 8, operand/result width in bits (>=4, power of two)
LARGURA_FUNCT, 4, funct field width (>=4)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
valid_in  input  1  operation request; accepted when valid_in && ready_in at a rising edge
opAlu  input  2  00 add (lw/sw), 01 sub (branch), 10 R-type (use funct), 11 error
funct  input  LARGURA_FUNCT  R-type operation code
a  input  LARGURA  operand A
b  input  LARGURA  operand B; shift amount is b[$clog2(LARGURA)-1:0]
ready_in  output  1  high when idle and reset is deasserted
valid_out  output  1  one-cycle pulse: result and flags valid
resultado  output  LARGURA  registered result
zero  output  1  resultado == 0, registered with the result
overflow  output  1  signed overflow for add/sub; 0 for all other ops
erro  output  1  unsupported opAlu/funct; resultado = 0

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = OCIOSO; valid_out, resultado, zero, overflow, erro = 0.
  - Iteration registers are cleared; no stale valid_out after release.
- ready_in = (state == OCIOSO) && !reset, combinational.
- Operands, opAlu and funct are sampled only at the acceptance edge. valid_in while busy is ignored, not queued.
- funct codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt (signed), 0101 xor, 0110 nor, 0111 sltu
  - 1000 sll, 1001 srl, 1010 sra, 1011 mul (low LARGURA bits)
  - all others: erro
- Single-cycle class (add/sub/logic/slt/sltu, error, and shifts with amount 0):
  - Result is registered at the acceptance edge; valid_out is high the following cycle.
  - Latency 1; back-to-back acceptance every cycle is allowed.
- Shift class (amount s >= 1):
  - Acceptance edge loads the operand and cnt = s; state = EXEC.
  - Each EXEC edge shifts one bit (sra replicates the MSB) and decrements cnt.
  - The edge with cnt == 1 registers the final result, raises valid_out and returns to OCIOSO.
  - Latency s+1 edges; ready_in is low for s cycles.
- Multiply class:
  - Shift-add over LARGURA iterations, cnt = LARGURA; same EXEC/exit rules as shifts.
  - Latency LARGURA+1; only the low LARGURA bits are kept.
- States: OCIOSO -> EXEC on acceptance of a multi-cycle op; EXEC -> OCIOSO on the cnt == 1 edge. Reset forces OCIOSO.
- valid_out is high for exactly one cycle per accepted operation. It may coincide with ready_in and a new acceptance.
- slt/sltu result: {LARGURA-1 zeros, bit}.
- overflow:
  - add: signs of a and b equal, result sign differs.
  - sub: signs differ, result sign differs from a.
- Width: all arithmetic is modulo 2^LARGURA; carries are discarded.

Decomposition:
- Package ula_pkg holds:
  - opAlu codes and funct codes as named constants
  - state enum OCIOSO/EXEC
  - internal operation enum
  - class enum UNICO/ITER/ERRO
- Sub-module decod_ula: combinational decode of opAlu/funct into internal operation and class. This is the generalised, widened control decoder.
- Datapath and FSM stay in ula_sequencial.

Test Plan:
1. Reset, then accept opAlu=00 a=8'h05 b=8'h03 -> one cycle later valid_out=1, resultado=8'h08, zero=0, overflow=0. Then add 8'h7F+8'h01 -> 8'h80, overflow=1.
2. opAlu=01 a=8'h07 b=8'h07 -> resultado=8'h00, zero=1. R slt a=8'hFF b=8'h01 -> 8'h01; sltu with the same operands -> 8'h00. Issue back-to-back on consecutive cycles, each valid_out one cycle after acceptance.
3. sll a=8'h01 b=8'h03 -> ready_in low 3 cycles, valid_out after 4 edges, resultado=8'h08. valid_in pulsed while busy is not accepted. sra a=8'h80 b=8'h02 -> 8'hE0. sll with b=8'h08 (amount 0) -> 8'h01, latency 1.
4. mul a=8'h0D b=8'h0B -> valid_out after 9 edges, resultado=8'h8F. mul 8'h10*8'h10 -> 8'h00, zero=1.
5. opAlu=11, and R-type funct=4'b1111 -> erro=1, resultado=0, latency 1, ready_in stays 1.
6. Assert reset asynchronously after 3 EXEC edges of a mul -> valid_out, resultado and flags go to 0 immediately; after release ready_in=1, no valid_out; a fresh add completes normally.
